dmac_buf_arbiter: RTL and testbench

//  Shares one dmac_buffer write side between CHANNEL_COUNT channel read engines.

---
 rtl/dmac_pkg.sv | 33 +++
 rtl/dmac_rr_arb.sv | 42 ++++
 rtl/dmac_buf_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dmac_buf_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// -----------------------------------------------------------------------------
// dmac_pkg
//   Shared types and helpers for the DMA controller buffer arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, CMD, DATA)
//   - dmac_cmd_t  : command record as seen at the buffer's cmd_in side,
//                   laid out for the default 32-bit address configuration
//   - rr_next     : round-robin successor of a channel index
// -----------------------------------------------------------------------------
package dmac_pkg;

    localparam int DMAC_ADDR_WD = 32;
    localparam int DMAC_OFF_WD  = $clog2(DMAC_ADDR_WD / 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [DMAC_OFF_WD-1:0]  src_offset;
        logic [DMAC_ADDR_WD-1:0] dst_addr;
        logic [1:0]              burst;
        logic [DMAC_ADDR_WD-1:0] len;
        logic [2:0]              size;
    } dmac_cmd_t;

    // Next channel after cur, wrapping modulo n (n need not be a power of 2).
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/dmac_rr_arb.sv
// -----------------------------------------------------------------------------
// dmac_rr_arb
//   Combinational round-robin pick: the first asserted request at or above
//   ptr, wrapping modulo N.
// Ports
//   req  in  N          request vector
//   ptr  in  $clog2(N)  highest-priority position
//   any  out 1          at least one request present
//   idx  out $clog2(N)  winning request index (0 when any=0)
// -----------------------------------------------------------------------------
module dmac_rr_arb #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0] k;

    always_comb begin
        any = 1'b0;
        idx = '0;
        k   = '0;
        // Scan N positions starting at ptr; the extra bit in k absorbs
        // ptr+i before the wrap is folded back below N.
        for (int i = 0; i < N; i++) begin
            k = {1'b0, ptr} + (IDX_W+1)'(i);
            if (k >= (IDX_W+1)'(N)) begin
                k = k - (IDX_W+1)'(N);
            end
            if (!any && req[k[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dmac_buf_arbiter.sv
// -----------------------------------------------------------------------------
// dmac_buf_arbiter
//   Shares the single dmac_buffer write side between CHANNEL_COUNT channel
//   read engines. One channel is granted round-robin; its command and then
//   its data beats (through the last beat) are forwarded combinationally to
//   the buffer, after which a new grant is made.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   ch_cmd_valid/ready         per-channel command handshake (ready one-hot/0)
//   ch_cmd_src_offset/dst_addr/burst/len/size   packed per-channel commands
//   ch_data_valid/ready        per-channel data handshake (ready one-hot/0)
//   ch_data, ch_data_last      packed per-channel data beats
//   cmd_out_*                  command to buffer cmd_in_*
//   data_out_valid/ready, data_out, data_out_last   data to buffer data_in_*
//   grant_id                   channel currently owning the buffer
//   busy                       FSM not idle
//   len_err                    pulse with a beat whose count disagrees with len
// -----------------------------------------------------------------------------
module dmac_buf_arbiter
    import dmac_pkg::*;
#(
    parameter int ADDR_WD       = 32,
    parameter int DATA_WD       = 32,
    parameter int CHANNEL_COUNT = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [CHANNEL_COUNT-1:0]                       ch_cmd_valid,
    output logic [CHANNEL_COUNT-1:0]                       ch_cmd_ready,
    input  logic [CHANNEL_COUNT*$clog2(ADDR_WD/8)-1:0]     ch_cmd_src_offset,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0]               ch_cmd_dst_addr,
    input  logic [CHANNEL_COUNT*2-1:0]                     ch_cmd_burst,
    input  logic [CHANNEL_COUNT*ADDR_WD-1:0]               ch_cmd_len,
    input  logic [CHANNEL_COUNT*3-1:0]                     ch_cmd_size,
    input  logic [CHANNEL_COUNT-1:0]                       ch_data_valid,
    output logic [CHANNEL_COUNT-1:0]                       ch_data_ready,
    input  logic [CHANNEL_COUNT*DATA_WD-1:0]               ch_data,
    input  logic [CHANNEL_COUNT-1:0]                       ch_data_last,
    output logic                                           cmd_out_valid,
    input  logic                                           cmd_out_ready,
    output logic [$clog2(ADDR_WD/8)-1:0]                   cmd_out_src_offset,
    output logic [ADDR_WD-1:0]                             cmd_out_dst_addr,
    output logic [1:0]                                     cmd_out_burst,
    output logic [ADDR_WD-1:0]                             cmd_out_len,
    output logic [2:0]                                     cmd_out_size,
    output logic                                           data_out_valid,
    input  logic                                           data_out_ready,
    output logic [DATA_WD-1:0]                             data_out,
    output logic                                           data_out_last,
    output logic [$clog2(CHANNEL_COUNT)-1:0]               grant_id,
    output logic                                           busy,
    output logic                                           len_err
);

    localparam int N     = CHANNEL_COUNT;
    localparam int IDX_W = $clog2(N);
    localparam int OFF_W = $clog2(ADDR_WD / 8);
    localparam int CNT_W = $clog2(MAX_BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST_LEN - 1);

    arb_state_e        state_q,    state_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  exp_len_q,  exp_len_d;

    logic              arb_any;
    logic [IDX_W-1:0]  arb_idx;
    logic              cmd_hs;
    logic              data_hs;

    // Per-channel views of the packed input buses.
    logic [OFF_W-1:0]   off_arr   [N];
    logic [ADDR_WD-1:0] dst_arr   [N];
    logic [1:0]         burst_arr [N];
    logic [ADDR_WD-1:0] len_arr   [N];
    logic [2:0]         size_arr  [N];
    logic [DATA_WD-1:0] data_arr  [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign off_arr[g]   = ch_cmd_src_offset[g*OFF_W +: OFF_W];
        assign dst_arr[g]   = ch_cmd_dst_addr[g*ADDR_WD +: ADDR_WD];
        assign burst_arr[g] = ch_cmd_burst[g*2 +: 2];
        assign len_arr[g]   = ch_cmd_len[g*ADDR_WD +: ADDR_WD];
        assign size_arr[g]  = ch_cmd_size[g*3 +: 3];
        assign data_arr[g]  = ch_data[g*DATA_WD +: DATA_WD];
    end

    dmac_rr_arb #(
        .N (N)
    ) u_rr_arb (
        .req (ch_cmd_valid),
        .ptr (rr_ptr_q),
        .any (arb_any),
        .idx (arb_idx)
    );

    // Payloads follow the grant unconditionally; only valid/ready are gated
    // by state, so forwarding adds no latency.
    assign cmd_out_src_offset = off_arr[grant_id_q];
    assign cmd_out_dst_addr   = dst_arr[grant_id_q];
    assign cmd_out_burst      = burst_arr[grant_id_q];
    assign cmd_out_len        = len_arr[grant_id_q];
    assign cmd_out_size       = size_arr[grant_id_q];
    assign data_out           = data_arr[grant_id_q];
    assign data_out_last      = ch_data_last[grant_id_q];

    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

    assign cmd_hs  = (state_q == CMD)  && ch_cmd_valid[grant_id_q]  && cmd_out_ready;
    assign data_hs = (state_q == DATA) && ch_data_valid[grant_id_q] && data_out_ready;

    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        beat_cnt_d     = beat_cnt_q;
        exp_len_d      = exp_len_q;
        cmd_out_valid  = 1'b0;
        ch_cmd_ready   = '0;
        data_out_valid = 1'b0;
        ch_data_ready  = '0;
        len_err        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_id_d = arb_idx;
                    state_d    = CMD;
                end
            end

            CMD: begin
                cmd_out_valid            = ch_cmd_valid[grant_id_q];
                ch_cmd_ready[grant_id_q] = cmd_out_ready;
                if (cmd_hs) begin
                    beat_cnt_d = '0;
                    exp_len_d  = len_arr[grant_id_q][CNT_W-1:0];
                    state_d    = DATA;
                end
            end

            DATA: begin
                data_out_valid            = ch_data_valid[grant_id_q];
                ch_data_ready[grant_id_q] = data_out_ready;
                if (data_hs) begin
                    // Flag a short/long burst but keep forwarding; only a
                    // real last beat releases the buffer.
                    len_err = ( ch_data_last[grant_id_q] && (beat_cnt_q != exp_len_q)) ||
                              (!ch_data_last[grant_id_q] && (beat_cnt_q == CNT_MAX));
                    if (beat_cnt_q != CNT_MAX) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    if (ch_data_last[grant_id_q]) begin
                        rr_ptr_d = IDX_W'(rr_next(int'(grant_id_q), N));
                        state_d  = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            exp_len_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            exp_len_q  <= exp_len_d;
        end
    end

endmodule

// File: tb/tb_dmac_buf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmac_buf_arbiter
//   Directed bench: channel behaviour is modelled in the stimulus process,
//   expected commands/beats are queued when a request is posted and popped
//   when the arbiter forwards them to the buffer side.
// -----------------------------------------------------------------------------
`define CHK(tag, obs, exp) \
    begin \
        tests++; \
        assert ((obs) === (exp)) else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_dmac_buf_arbiter;
    import dmac_pkg::*;

    localparam int N   = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MBL = 16;
    localparam int OW  = 2;
    localparam int IW  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    ch_cmd_valid, ch_cmd_ready;
    logic [N*OW-1:0] ch_cmd_src_offset;
    logic [N*AW-1:0] ch_cmd_dst_addr, ch_cmd_len;
    logic [N*2-1:0]  ch_cmd_burst;
    logic [N*3-1:0]  ch_cmd_size;
    logic [N-1:0]    ch_data_valid, ch_data_ready, ch_data_last;
    logic [N*DW-1:0] ch_data;
    logic            cmd_out_valid, cmd_out_ready;
    logic [OW-1:0]   cmd_out_src_offset;
    logic [AW-1:0]   cmd_out_dst_addr, cmd_out_len;
    logic [1:0]      cmd_out_burst;
    logic [2:0]      cmd_out_size;
    logic            data_out_valid, data_out_ready, data_out_last;
    logic [DW-1:0]   data_out;
    logic [IW-1:0]   grant_id;
    logic            busy, len_err;

    always #5 clk = ~clk;

    dmac_buf_arbiter #(
        .ADDR_WD(AW), .DATA_WD(DW), .CHANNEL_COUNT(N), .MAX_BURST_LEN(MBL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_cmd_valid(ch_cmd_valid), .ch_cmd_ready(ch_cmd_ready),
        .ch_cmd_src_offset(ch_cmd_src_offset), .ch_cmd_dst_addr(ch_cmd_dst_addr),
        .ch_cmd_burst(ch_cmd_burst), .ch_cmd_len(ch_cmd_len), .ch_cmd_size(ch_cmd_size),
        .ch_data_valid(ch_data_valid), .ch_data_ready(ch_data_ready),
        .ch_data(ch_data), .ch_data_last(ch_data_last),
        .cmd_out_valid(cmd_out_valid), .cmd_out_ready(cmd_out_ready),
        .cmd_out_src_offset(cmd_out_src_offset), .cmd_out_dst_addr(cmd_out_dst_addr),
        .cmd_out_burst(cmd_out_burst), .cmd_out_len(cmd_out_len), .cmd_out_size(cmd_out_size),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .data_out(data_out), .data_out_last(data_out_last),
        .grant_id(grant_id), .busy(busy), .len_err(len_err)
    );

    // Channel model state
    logic [OW-1:0] m_off   [N];
    logic [AW-1:0] m_dst   [N];
    logic [AW-1:0] m_len   [N];
    logic [1:0]    m_burst [N];
    logic [2:0]    m_size  [N];
    logic [DW-1:0] m_data  [N];
    int nbeats [N];
    int lastpos[N];
    int bidx   [N];
    int tagv   [N];
    int tag_ctr;
    bit noise1;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign ch_cmd_src_offset[g*OW +: OW] = m_off[g];
        assign ch_cmd_dst_addr[g*AW +: AW]   = m_dst[g];
        assign ch_cmd_len[g*AW +: AW]        = m_len[g];
        assign ch_cmd_burst[g*2 +: 2]        = m_burst[g];
        assign ch_cmd_size[g*3 +: 3]         = m_size[g];
        assign ch_data[g*DW +: DW]           = m_data[g];
    end

    typedef struct {
        int        ch;
        dmac_cmd_t cmd;
    } exp_cmd_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        logic          last;
        logic          err;
    } exp_beat_t;

    exp_cmd_t  cq[$];
    exp_beat_t dq[$];

    int tests = 0;
    int fails = 0;

    function automatic logic [DW-1:0] mk_data(int c, int k, int t);
        return {8'(c), 8'(k), 16'(t)};
    endfunction

    // Beat k is 0-based; the count saturates at MBL-1.
    function automatic logic exp_err(int k, logic last, int len);
        int cnt;
        cnt = (k > MBL - 1) ? MBL - 1 : k;
        return (last && (cnt != (len % MBL))) || (!last && (cnt == MBL - 1));
    endfunction

    function automatic bit ch_idle(int c);
        return !ch_cmd_valid[c] && !ch_data_valid[c];
    endfunction

    task automatic push_beats(int c, int from, int to);
        exp_beat_t eb;
        for (int k = from; k < to; k++) begin
            eb.ch   = c;
            eb.data = mk_data(c, k, tagv[c]);
            eb.last = (lastpos[c] == k + 1);
            eb.err  = exp_err(k, eb.last, int'(m_len[c]));
            dq.push_back(eb);
        end
    endtask

    task automatic post_req(int c, int len, int nb, int lp);
        exp_cmd_t ec;
        tag_ctr++;
        tagv[c]    = tag_ctr;
        m_off[c]   = OW'(c);
        m_dst[c]   = 32'hA000_0000 + 32'(c * 256) + 32'(tag_ctr);
        m_len[c]   = AW'(len);
        m_burst[c] = 2'(c % 3);
        m_size[c]  = 3'(c % 8);
        nbeats[c]  = nb;
        lastpos[c] = lp;
        bidx[c]    = 0;
        ch_cmd_valid[c] = 1'b1;
        ec.ch = c;
        ec.cmd.src_offset = m_off[c];
        ec.cmd.dst_addr   = m_dst[c];
        ec.cmd.burst      = m_burst[c];
        ec.cmd.len        = m_len[c];
        ec.cmd.size       = m_size[c];
        cq.push_back(ec);
        push_beats(c, 0, nb);
    endtask

    task automatic present(int c);
        ch_data_valid[c] = 1'b1;
        m_data[c]        = mk_data(c, bidx[c], tagv[c]);
        ch_data_last[c]  = (lastpos[c] == bidx[c] + 1);
    endtask

    // One clock: check the buffer side mid-cycle, then advance the channel
    // models by the handshakes that the rising edge just completed.
    task automatic step();
        logic [N-1:0] chs, dhs;
        exp_cmd_t  ec;
        exp_beat_t eb;
        dmac_cmd_t oc;
        @(negedge clk);
        chs = ch_cmd_valid & ch_cmd_ready;
        dhs = ch_data_valid & ch_data_ready;
        `CHK("ready_only_granted", (ch_cmd_ready | ch_data_ready) & ~(N'(1) << grant_id), N'(0))
        if (cmd_out_valid && cmd_out_ready) begin
            if (cq.size() == 0) begin
                tests++; fails++;
                $error("FAIL cmd_unexpected: observed grant %0d expected none", grant_id);
            end else begin
                ec = cq.pop_front();
                oc.src_offset = cmd_out_src_offset;
                oc.dst_addr   = cmd_out_dst_addr;
                oc.burst      = cmd_out_burst;
                oc.len        = cmd_out_len;
                oc.size       = cmd_out_size;
                `CHK("cmd_grant", grant_id, IW'(ec.ch))
                `CHK("cmd_fields", oc, ec.cmd)
                `CHK("cmd_ready_back", ch_cmd_ready[grant_id], 1'b1)
            end
        end
        if (data_out_valid && data_out_ready) begin
            if (dq.size() == 0) begin
                tests++; fails++;
                $error("FAIL beat_unexpected: observed %0h expected none", data_out);
            end else begin
                eb = dq.pop_front();
                `CHK("beat_grant", grant_id, IW'(eb.ch))
                `CHK("beat_data", data_out, eb.data)
                `CHK("beat_last", data_out_last, eb.last)
                `CHK("beat_len_err", len_err, eb.err)
            end
        end else begin
            `CHK("len_err_idle", len_err, 1'b0)
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (chs[c]) begin
                ch_cmd_valid[c] = 1'b0;
                bidx[c] = 0;
                if (nbeats[c] > 0) present(c);
            end
            if (dhs[c]) begin
                bidx[c]++;
                if (bidx[c] < nbeats[c]) present(c);
                else begin
                    ch_data_valid[c] = 1'b0;
                    ch_data_last[c]  = 1'b0;
                end
            end
        end
        if (noise1) begin
            ch_data_valid[1] = 1'($urandom_range(0, 1));
            ch_data_last[1]  = 1'($urandom_range(0, 1));
            m_data[1]        = $urandom;
        end
    endtask

    task automatic wait_idle(int c, int budget);
        int n = 0;
        while (!ch_idle(c) && n < budget) begin
            step();
            n++;
        end
        `CHK("xfer_complete", ch_idle(c), 1'b1)
    endtask

    task automatic wait_bidx(int c, int target, int budget);
        int n = 0;
        while (!(bidx[c] == target && ch_data_valid[c]) && n < budget) begin
            step();
            n++;
        end
        `CHK("reach_beat", bidx[c], target)
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] snap;
        ch_cmd_valid = '0; ch_data_valid = '0; ch_data_last = '0;
        cmd_out_ready = 1'b1; data_out_ready = 1'b1;
        noise1 = 1'b0; tag_ctr = 0;
        for (int c = 0; c < N; c++) begin
            m_off[c] = '0; m_dst[c] = '0; m_len[c] = '0; m_burst[c] = '0;
            m_size[c] = '0; m_data[c] = '0;
            nbeats[c] = 0; lastpos[c] = 0; bidx[c] = 0; tagv[c] = 0;
        end

        // Reset state
        #12;
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_grant", grant_id, IW'(0))
        `CHK("rst_cmd_valid", cmd_out_valid, 1'b0)
        `CHK("rst_data_valid", data_out_valid, 1'b0)
        `CHK("rst_readies", ch_cmd_ready | ch_data_ready, N'(0))
        `CHK("rst_len_err", len_err, 1'b0)
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ch0, ch3, ch7 together; a fresh ch0 request must wait for ch7
        post_req(0, 0, 1, 1);
        post_req(3, 0, 1, 1);
        post_req(7, 0, 1, 1);
        wait_idle(0, 20);
        post_req(0, 0, 1, 1);
        wait_idle(0, 40);
        `CHK("t2_queues_drained", cq.size() + dq.size(), 0)

        // Single ch2 transfer, len=3, four beats; grant after one cycle
        post_req(2, 3, 4, 4);
        `CHK("t1_idle_before_grant", busy, 1'b0)
        `CHK("t1_no_cmd_yet", cmd_out_valid, 1'b0)
        step();
        `CHK("t1_busy", busy, 1'b1)
        `CHK("t1_grant", grant_id, IW'(2))
        `CHK("t1_cmd_valid", cmd_out_valid, 1'b1)
        wait_idle(2, 20);
        `CHK("t1_back_idle", busy, 1'b0)

        // rr_ptr now 3: ch3 must win over ch2
        post_req(3, 1, 2, 2);
        post_req(2, 1, 2, 2);
        wait_idle(2, 30);

        // ch1 data noise while ch6 owns the buffer
        noise1 = 1'b1;
        post_req(6, 4, 5, 5);
        wait_idle(6, 30);
        noise1 = 1'b0;
        ch_data_valid[1] = 1'b0;
        ch_data_last[1]  = 1'b0;

        // Backpressure on command, then mid-data
        cmd_out_ready = 1'b0;
        post_req(4, 3, 4, 4);
        for (int i = 0; i < 5; i++) begin
            step();
            `CHK("t3_cmd_valid_held", cmd_out_valid, 1'b1)
            `CHK("t3_cmd_dst_stable", cmd_out_dst_addr, m_dst[4])
            `CHK("t3_cmd_ready_low", ch_cmd_ready, N'(0))
        end
        cmd_out_ready = 1'b1;
        wait_bidx(4, 2, 20);
        data_out_ready = 1'b0;
        snap = mk_data(4, 2, tagv[4]);
        for (int i = 0; i < 5; i++) begin
            step();
            `CHK("t3_data_valid_held", data_out_valid, 1'b1)
            `CHK("t3_data_stable", data_out, snap)
            `CHK("t3_data_ready_low", ch_data_ready, N'(0))
        end
        data_out_ready = 1'b1;
        wait_idle(4, 20);

        // Early last: len=3 but last on beat 2
        post_req(0, 3, 2, 2);
        wait_idle(0, 20);
        `CHK("t4_idle_after_early_last", busy, 1'b0)

        // 16 beats without last: error on beat 16, FSM holds in DATA
        post_req(1, 15, 16, 0);
        wait_idle(1, 40);
        step();
        step();
        `CHK("t4_still_busy", busy, 1'b1)
        `CHK("t4_still_granted", grant_id, IW'(1))
        nbeats[1]  = 17;
        lastpos[1] = 17;
        push_beats(1, 16, 17);
        present(1);
        wait_idle(1, 20);
        `CHK("t4_idle_after_last", busy, 1'b0)

        // Move rr_ptr to 4, then reset during ch5 beat 2
        post_req(3, 0, 1, 1);
        wait_idle(3, 20);
        post_req(5, 3, 4, 4);
        wait_bidx(5, 1, 20);
        #2;
        rst_n = 1'b0;
        #1;
        `CHK("t5_busy_cleared", busy, 1'b0)
        `CHK("t5_readies_cleared", ch_cmd_ready | ch_data_ready, N'(0))
        `CHK("t5_data_valid_cleared", data_out_valid, 1'b0)
        `CHK("t5_grant_cleared", grant_id, IW'(0))
        cq.delete();
        dq.delete();
        ch_cmd_valid = '0; ch_data_valid = '0; ch_data_last = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        post_req(0, 1, 2, 2);
        post_req(5, 1, 2, 2);
        wait_idle(0, 20);
        wait_idle(5, 20);

        `CHK("final_cmd_queue_empty", cq.size(), 0)
        `CHK("final_beat_queue_empty", dq.size(), 0)

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
